// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I datapath: sequences fetch/decode/execute/memory/writeback.
// Optional feature: define ILLEGAL_TRAP_EN to trap unknown opcodes in a sticky TRAP state.
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_control,
  output logic [1:0]       imm_src,
  output logic             reg_write,
  output logic [CNT_W-1:0] instret,
  output logic             illegal
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
`ifdef ILLEGAL_TRAP_EN
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
`else
    S_JAL      = 4'd10
`endif
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] instret_reg;
  logic             retire;
  logic [2:0]       alu_dec;

  // ALU decode for R/I-type (ALUOp = 10); op[5] separates R-type sub from addi.
  always_comb begin
    alu_dec = ALU_ADD;
    case (funct3)
      3'b000:  alu_dec = (funct7b5 && op[5]) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_dec = ALU_SLT;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      default: alu_dec = ALU_ADD;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    imm_src     = 2'b00;
    reg_write   = 1'b0;
    retire      = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegal     = 1'b0;
`endif
    case (state_reg)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is precomputed here into ALUOut from OldPC + B-immediate.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = 2'b10;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECUTER;
          OP_I:         state_next = S_EXECUTEI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
`ifdef ILLEGAL_TRAP_EN
          default:      state_next = S_TRAP;
`else
          default:      state_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        imm_src    = (op == OP_LW) ? 2'b00 : 2'b01;
        state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_EXECUTER: begin
        alu_src_a   = 2'b10;
        alu_control = alu_dec;
        state_next  = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_dec;
        state_next  = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        pc_write    = zero;
        retire      = 1'b1;
        state_next  = S_FETCH;
      end
      S_JAL: begin
        // PC+4 link value goes through ALUWB, which is where JAL retires.
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write   = 1'b1;
        state_next = S_ALUWB;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        illegal    = 1'b1;
        state_next = S_TRAP;
      end
`endif
      default: state_next = S_FETCH;
    endcase

    // Architectural side effects are suppressed in any cycle that reset is high.
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      retire    = 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal   = 1'b0;
`endif
    end
  end

`ifndef ILLEGAL_TRAP_EN
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      instret_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retire) instret_reg <= instret_reg + CNT_W'(1);
    end
  end

  assign instret = instret_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller: every cycle checks the packed control word,
// instret and illegal against hand-computed constants. Honours ILLEGAL_TRAP_EN like the RTL.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  op = 7'b0110011;
  logic [2:0]  funct3 = 3'b000;
  logic        funct7b5 = 1'b0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic        pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0]  alu_control;
  logic [31:0] instret;
  logic [15:0] ctrl_vec;

  int n_compared = 0;
  int n_mismatch = 0;

  multicycle_controller #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .imm_src(imm_src), .reg_write(reg_write), .instret(instret), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b, alu_control, imm_src, reg_write}
  assign ctrl_vec = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                     alu_src_b, alu_control, imm_src, reg_write};

  localparam logic [15:0] F_GO    = 16'b1_0_0_1_10_00_10_000_00_0;
  localparam logic [15:0] F_IDLE  = 16'b0_0_0_0_10_00_10_000_00_0;
  localparam logic [15:0] DEC     = 16'b0_0_0_0_00_01_01_000_10_0;
  localparam logic [15:0] EXR_ADD = 16'b0_0_0_0_00_10_00_000_00_0;
  localparam logic [15:0] EXR_SUB = 16'b0_0_0_0_00_10_00_001_00_0;
  localparam logic [15:0] EXR_SLT = 16'b0_0_0_0_00_10_00_101_00_0;
  localparam logic [15:0] EXI_ADD = 16'b0_0_0_0_00_10_01_000_00_0;
  localparam logic [15:0] EXI_AND = 16'b0_0_0_0_00_10_01_010_00_0;
  localparam logic [15:0] EXI_OR  = 16'b0_0_0_0_00_10_01_011_00_0;
  localparam logic [15:0] WB_ALU  = 16'b0_0_0_0_00_00_00_000_00_1;
  localparam logic [15:0] MA_LW   = 16'b0_0_0_0_00_10_01_000_00_0;
  localparam logic [15:0] MA_SW   = 16'b0_0_0_0_00_10_01_000_01_0;
  localparam logic [15:0] MREAD   = 16'b0_1_0_0_00_00_00_000_00_0;
  localparam logic [15:0] MWB     = 16'b0_0_0_0_01_00_00_000_00_1;
  localparam logic [15:0] MWRITE  = 16'b0_1_1_0_00_00_00_000_00_0;
  localparam logic [15:0] BEQ_T   = 16'b1_0_0_0_00_10_00_001_00_0;
  localparam logic [15:0] BEQ_NT  = 16'b0_0_0_0_00_10_00_001_00_0;
  localparam logic [15:0] JAL_V   = 16'b1_0_0_0_00_01_10_000_00_0;
  localparam logic [15:0] ALL0    = 16'h0000;

  task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatch++;
      $display("FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs on the falling edge, check the settled outputs 1ns later.
  task automatic step(input string tag, input logic rst, input logic mr, input logic z,
                      input logic [15:0] exp_ctrl, input logic [31:0] exp_cnt,
                      input logic exp_ill = 1'b0);
    @(negedge clk);
    reset = rst;
    mem_ready = mr;
    zero = z;
    #1;
    $display("[%0t] %-12s ctrl=%04h instret=%0d illegal=%0b", $time, tag, ctrl_vec, instret, illegal);
    check_eq({tag, "_ctrl"}, {16'h0, ctrl_vec}, {16'h0, exp_ctrl});
    check_eq({tag, "_cnt"}, instret, exp_cnt);
    check_eq({tag, "_ill"}, {31'h0, illegal}, {31'h0, exp_ill});
  endtask

  task automatic run_alu(input string tag, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic [15:0] exp_ex, input logic [31:0] cnt);
    op = o;
    funct3 = f3;
    funct7b5 = f7;
    step({tag, "_f"}, 1'b0, 1'b1, 1'b0, F_GO, cnt);
    step({tag, "_d"}, 1'b0, 1'b1, 1'b0, DEC, cnt);
    step({tag, "_ex"}, 1'b0, 1'b1, 1'b0, exp_ex, cnt);
    step({tag, "_wb"}, 1'b0, 1'b1, 1'b0, WB_ALU, cnt);
  endtask

  initial begin
    // Power-up reset: enables stay low even though mem_ready is high in FETCH.
    step("rst0", 1'b1, 1'b1, 1'b0, F_IDLE, 0);
    step("rst1", 1'b1, 1'b1, 1'b0, F_IDLE, 0);

    // add interrupted by two reset cycles starting in EXECUTER
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
    step("addr_f", 1'b0, 1'b1, 1'b0, F_GO, 0);
    step("addr_d", 1'b0, 1'b1, 1'b0, DEC, 0);
    step("addr_exrst", 1'b1, 1'b1, 1'b0, EXR_ADD, 0);
    step("addr_frst", 1'b1, 1'b1, 1'b0, F_IDLE, 0);

    run_alu("add", 7'b0110011, 3'b000, 1'b0, EXR_ADD, 0);

    // add with reset landing in ALUWB: reg_write must be suppressed, instret cleared
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
    step("add2_f", 1'b0, 1'b1, 1'b0, F_GO, 1);
    step("add2_d", 1'b0, 1'b1, 1'b0, DEC, 1);
    step("add2_ex", 1'b0, 1'b1, 1'b0, EXR_ADD, 1);
    step("add2_wbrst", 1'b1, 1'b1, 1'b0, ALL0, 1);

    run_alu("sub", 7'b0110011, 3'b000, 1'b1, EXR_SUB, 0);
    run_alu("addi", 7'b0010011, 3'b000, 1'b1, EXI_ADD, 1);
    run_alu("slt", 7'b0110011, 3'b010, 1'b0, EXR_SLT, 2);
    run_alu("andi", 7'b0010011, 3'b111, 1'b0, EXI_AND, 3);
    run_alu("ori", 7'b0010011, 3'b110, 1'b0, EXI_OR, 4);

    // lw: 3 fetch stalls + 2 read stalls = 10 cycles
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    for (int i = 0; i < 3; i++) step("lw_fstall", 1'b0, 1'b0, 1'b0, F_IDLE, 5);
    step("lw_f", 1'b0, 1'b1, 1'b0, F_GO, 5);
    step("lw_d", 1'b0, 1'b1, 1'b0, DEC, 5);
    step("lw_ma", 1'b0, 1'b1, 1'b0, MA_LW, 5);
    for (int i = 0; i < 2; i++) step("lw_rstall", 1'b0, 1'b0, 1'b0, MREAD, 5);
    step("lw_rd", 1'b0, 1'b1, 1'b0, MREAD, 5);
    step("lw_wb", 1'b0, 1'b1, 1'b0, MWB, 5);

    // sw with one write stall: mem_write high for two cycles
    op = 7'b0100011; funct3 = 3'b010;
    step("sw_f", 1'b0, 1'b1, 1'b0, F_GO, 6);
    step("sw_d", 1'b0, 1'b1, 1'b0, DEC, 6);
    step("sw_ma", 1'b0, 1'b1, 1'b0, MA_SW, 6);
    step("sw_wstall", 1'b0, 1'b0, 1'b0, MWRITE, 6);
    step("sw_w", 1'b0, 1'b1, 1'b0, MWRITE, 6);

    op = 7'b1100011; funct3 = 3'b000;
    step("beqt_f", 1'b0, 1'b1, 1'b0, F_GO, 7);
    step("beqt_d", 1'b0, 1'b1, 1'b0, DEC, 7);
    step("beqt_b", 1'b0, 1'b1, 1'b1, BEQ_T, 7);
    step("beqn_f", 1'b0, 1'b1, 1'b0, F_GO, 8);
    step("beqn_d", 1'b0, 1'b1, 1'b0, DEC, 8);
    step("beqn_b", 1'b0, 1'b1, 1'b0, BEQ_NT, 8);

    op = 7'b1101111;
    step("jal_f", 1'b0, 1'b1, 1'b0, F_GO, 9);
    step("jal_d", 1'b0, 1'b1, 1'b0, DEC, 9);
    step("jal_j", 1'b0, 1'b1, 1'b0, JAL_V, 9);
    step("jal_wb", 1'b0, 1'b1, 1'b0, WB_ALU, 9);

    // unknown opcode
    op = 7'b0000000;
    step("ill_f", 1'b0, 1'b1, 1'b0, F_GO, 10);
    step("ill_d", 1'b0, 1'b1, 1'b0, DEC, 10);
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) step("trap", 1'b0, 1'b1, 1'b1, ALL0, 10, 1'b1);
    step("trap_rst", 1'b1, 1'b1, 1'b1, ALL0, 10, 1'b0);
    step("post_trap", 1'b0, 1'b0, 1'b0, F_IDLE, 0, 1'b0);
`else
    step("nop_f", 1'b0, 1'b1, 1'b0, F_GO, 10);
    step("nop_d", 1'b0, 1'b1, 1'b0, DEC, 10);
    step("nop_f2", 1'b0, 1'b0, 1'b0, F_IDLE, 10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multicycle RV32I datapath. It sequences fetch, decode, execute, memory and writeback over several cycles.
- Drives the datapath enables, the mux selects, the ALU control and the immediate-format select (imm_src) consumed by the sign-extension unit.
- Stalls on a shared instruction/data memory ready signal and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter instret.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- op  input  7  instr[6:0] from the instruction register
- funct3  input  3  instr[14:12]
- funct7b5  input  1  instr[30]
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the current access this cycle
- pc_write  output  1  PC register enable
- adr_src  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  output  1  memory write strobe
- ir_write  output  1  instruction register and OldPC enable
- result_src  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- alu_src_a  output  2  00 = PC, 01 = OldPC, 10 = RD1
- alu_src_b  output  2  00 = RD2, 01 = ImmExt, 10 = constant 4
- alu_control  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- imm_src  output  2  00 I, 01 S, 10 B, 11 J
- reg_write  output  1  register file write enable
- instret  output  CNT_W  retired-instruction count
- illegal  output  1  illegal opcode trap flag (optional feature only)

Behaviour:
- Reset, synchronous:
  - next state is FETCH; instret = 0; illegal = 0.
  - pc_write, ir_write, mem_write and reg_write are forced to 0 during any cycle with reset = 1, including reset asserted mid-instruction.
- Outputs are combinational from state, plus op/funct decode, zero and mem_ready. Every output not listed for a state is 0; don't-care selects drive 0.
- States and transitions:
  - FETCH: adr_src = 0, alu_src_a = 00, alu_src_b = 10, alu_control = add, result_src = 10.
    - ir_write and pc_write assert only when mem_ready = 1, then go to DECODE.
    - Otherwise hold in FETCH.
  - DECODE: alu_src_a = 01, alu_src_b = 01, imm_src = 10, add (branch target precompute). Go by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - anything else -> FETCH (see Optional Feature)
  - MEMADR: alu_src_a = 10, alu_src_b = 01, add. imm_src = 00 for lw, 01 for sw. Go to MEMREAD if op = lw, else MEMWRITE.
  - MEMREAD: adr_src = 1. Hold until mem_ready = 1, then go to MEMWB.
  - MEMWB: result_src = 01, reg_write = 1, go to FETCH.
  - MEMWRITE: adr_src = 1, mem_write = 1 held until mem_ready = 1, then go to FETCH.
  - EXECUTER: alu_src_a = 10, alu_src_b = 00, ALUOp = 10, go to ALUWB.
  - EXECUTEI: alu_src_a = 10, alu_src_b = 01, imm_src = 00, ALUOp = 10, go to ALUWB.
  - ALUWB: result_src = 00, reg_write = 1, go to FETCH.
  - BEQ: alu_src_a = 10, alu_src_b = 00, sub, result_src = 00, pc_write = zero, go to FETCH.
  - JAL: alu_src_a = 01, alu_src_b = 10, add, result_src = 00, pc_write = 1, go to ALUWB.
- ALU decode when ALUOp = 10:
  - funct3 000: sub if funct7b5 = 1 and op[5] = 1, else add.
  - funct3 010: slt. 110: or. 111: and.
  - Any other funct3: add.
- instret increments by 1 (wrapping at 2^CNT_W) on the final cycle of each instruction:
  - MEMWB
  - MEMWRITE with mem_ready = 1
  - ALUWB
  - BEQ
  - Not on JAL itself, because JAL retires via ALUWB.
  - A DECODE exit to FETCH on an unknown opcode does not count.
- CPI with mem_ready tied to 1: lw 5, sw 4, R/I 4, beq 3, jal 4. Each memory stall cycle adds 1.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in DECODE goes to TRAP state.
  - TRAP sets illegal = 1 and holds all enables at 0.
  - The FSM stays in TRAP until reset.
  - instret is not incremented.
- Undefined: no TRAP state; illegal is tied to 0; an unknown opcode returns to FETCH as a NOP.

Test Plan:
- reset = 1 for 2 cycles mid-EXECUTER, then release -> state FETCH, instret = 0, pc_write/ir_write/mem_write/reg_write = 0 during reset.
- add x3,x1,x2 (op 0110011, funct3 000, f7b5 0), mem_ready = 1 -> states FETCH, DECODE, EXECUTER, ALUWB; alu_control 000; reg_write in cycle 4; instret 0 -> 1.
- sub (f7b5 = 1) and then addi with instr[30] = 1 (op 0010011) -> alu_control 001 for sub, 000 for addi.
- lw with mem_ready low for 3 cycles in FETCH and 2 in MEMREAD -> 10 cycles total; ir_write pulses exactly once; result_src = 01 in MEMWB.
- sw with mem_ready = 0 for 1 cycle in MEMWRITE -> mem_write high 2 consecutive cycles, imm_src = 01 in MEMADR.
- beq with zero = 1 then zero = 0 -> pc_write = 1 then 0 in BEQ. op 0000000 -> with ILLEGAL_TRAP_EN, illegal = 1 held and no enables; without it, back to FETCH with instret unchanged.
